// File: rtl/decoder_stage_controller.sv
`default_nettype none
// ============================================================================
// Module   : decoder_stage_controller
// Brief    : Stage sequencer for the union-find decoding array. It steps
//            through LOAD, repeated GROW/MERGE rounds, PEELING and RESULT.
//            DECODER_STAGE_CYCLE_COUNT_EN enables the decode latency counter.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_stage_controller #(
   parameter  int MAX_ITERATIONS      = 16,
   parameter  int MERGE_SETTLE_CYCLES = 3,
   parameter  int ITER_WIDTH          = 8,
   localparam int STAGE_WIDTH         = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   meas_valid,
   output logic                   meas_ready,
   input  logic                   busy_any,
   input  logic                   odd_cluster_any,
   input  logic                   peel_done_all,
   input  logic                   result_ready,
   output logic [STAGE_WIDTH-1:0] global_stage,
   output logic                   result_valid,
   output logic [ITER_WIDTH-1:0]  iteration_count,
   output logic                   iteration_overflow,
   output logic [31:0]            decode_cycles
);

   localparam int                      SETTLE_WIDTH  = $clog2(MERGE_SETTLE_CYCLES + 1);
   localparam logic [SETTLE_WIDTH-1:0] SETTLE_TARGET = SETTLE_WIDTH'(MERGE_SETTLE_CYCLES);
   localparam logic [SETTLE_WIDTH-1:0] SETTLE_ONE    = SETTLE_WIDTH'(1);
   localparam logic [ITER_WIDTH-1:0]   ITER_LIMIT    = ITER_WIDTH'(MAX_ITERATIONS);
   localparam logic [ITER_WIDTH-1:0]   ITER_ONE      = ITER_WIDTH'(1);
   localparam logic [ITER_WIDTH-1:0]   ITER_SAT      = '1;

   typedef enum logic [STAGE_WIDTH-1:0] {
      ST_IDLE         = 3'd0,
      ST_MEAS_LOAD    = 3'd1,
      ST_GROW         = 3'd2,
      ST_MERGE        = 3'd3,
      ST_PEELING      = 3'd4,
      ST_RESULT_VALID = 3'd5
   } stage_t;

   stage_t                  r_stage;
   stage_t                  w_stage_next;
   logic [SETTLE_WIDTH-1:0] r_settle_cnt;
   logic [SETTLE_WIDTH-1:0] w_settle_next;
   logic [SETTLE_WIDTH-1:0] w_settle_inc;
   logic [ITER_WIDTH-1:0]   r_iter_cnt;
   logic [ITER_WIDTH-1:0]   w_iter_next;
   logic                    r_overflow;
   logic                    w_overflow_next;
   logic                    r_peel_armed;
   logic                    r_meas_ready;
   logic                    r_result_valid;

   assign w_settle_inc = r_settle_cnt + SETTLE_ONE;

   always_comb begin
      w_stage_next    = r_stage;
      w_settle_next   = '0;
      w_iter_next     = r_iter_cnt;
      w_overflow_next = r_overflow;
      case (r_stage)
         ST_IDLE: begin
            if (meas_valid) begin
               w_stage_next    = ST_MEAS_LOAD;
               w_iter_next     = '0;
               w_overflow_next = 1'b0;
            end
         end
         ST_MEAS_LOAD: begin
            w_stage_next = ST_GROW;
         end
         ST_GROW: begin
            if (r_iter_cnt != ITER_SAT) begin
               w_iter_next = r_iter_cnt + ITER_ONE;
            end
            w_stage_next = ST_MERGE;
         end
         ST_MERGE: begin
            // Any busy cycle restarts the settle window; odd_cluster_any is
            // only trusted once the OR-tree has been quiet long enough.
            if (!busy_any) begin
               w_settle_next = w_settle_inc;
               if (w_settle_inc >= SETTLE_TARGET) begin
                  w_settle_next = '0;
                  if (!odd_cluster_any) begin
                     w_stage_next = ST_PEELING;
                  end else if (r_iter_cnt < ITER_LIMIT) begin
                     w_stage_next = ST_GROW;
                  end else begin
                     w_overflow_next = 1'b1;
                     w_stage_next    = ST_PEELING;
                  end
               end
            end
         end
         ST_PEELING: begin
            if (r_peel_armed && peel_done_all) begin
               w_stage_next = ST_RESULT_VALID;
            end
         end
         ST_RESULT_VALID: begin
            if (result_ready) begin
               w_stage_next = ST_IDLE;
            end
         end
         default: begin
            w_stage_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stage        <= ST_IDLE;
         r_settle_cnt   <= '0;
         r_iter_cnt     <= '0;
         r_overflow     <= 1'b0;
         r_peel_armed   <= 1'b0;
         r_meas_ready   <= 1'b1;
         r_result_valid <= 1'b0;
      end else begin
         r_stage        <= w_stage_next;
         r_settle_cnt   <= w_settle_next;
         r_iter_cnt     <= w_iter_next;
         r_overflow     <= w_overflow_next;
         // Stale peel_done_all from a previous syndrome is masked on entry.
         r_peel_armed   <= (r_stage == ST_PEELING) && (w_stage_next == ST_PEELING);
         r_meas_ready   <= (w_stage_next == ST_IDLE);
         r_result_valid <= (w_stage_next == ST_RESULT_VALID);
      end
   end

`ifdef DECODER_STAGE_CYCLE_COUNT_EN
   logic [31:0] r_decode_cycles;
   logic        w_accept;
   logic        w_counting;

   assign w_accept   = (r_stage == ST_IDLE) && meas_valid;
   assign w_counting = (r_stage == ST_MEAS_LOAD) || (r_stage == ST_GROW) ||
                       (r_stage == ST_MERGE)     || (r_stage == ST_PEELING);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_decode_cycles <= 32'd0;
      end else if (w_accept) begin
         r_decode_cycles <= 32'd0;
      end else if (w_counting && (r_decode_cycles != 32'hFFFF_FFFF)) begin
         r_decode_cycles <= r_decode_cycles + 32'd1;
      end
   end

   assign decode_cycles = r_decode_cycles;
`else
   assign decode_cycles = 32'd0;
`endif

   assign global_stage       = r_stage;
   assign meas_ready         = r_meas_ready;
   assign result_valid       = r_result_valid;
   assign iteration_count    = r_iter_cnt;
   assign iteration_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_decoder_stage_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_stage_controller
// Brief    : Randomized self-checking bench for decoder_stage_controller with
//            a transaction-level model of the stage sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_stage_controller;

   localparam int MAX_IT = 4;
   localparam int SETTLE = 3;
   localparam int ITER_W = 8;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_GROW   = 3'd2;
   localparam logic [2:0] S_MERGE  = 3'd3;
   localparam logic [2:0] S_PEEL   = 3'd4;
   localparam logic [2:0] S_RESULT = 3'd5;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              meas_valid = 1'b0;
   logic              busy_any = 1'b0;
   logic              odd_cluster_any = 1'b0;
   logic              peel_done_all = 1'b0;
   logic              result_ready = 1'b0;
   logic              meas_ready;
   logic [2:0]        global_stage;
   logic              result_valid;
   logic [ITER_W-1:0] iteration_count;
   logic              iteration_overflow;
   logic [31:0]       decode_cycles;

   int n_checks = 0;
   int n_fail   = 0;
   int m_iter   = 0;
   int m_dc     = 0;
   int m_ovf    = 0;

   always #5 clk = ~clk;

   decoder_stage_controller #(
      .MAX_ITERATIONS      (MAX_IT),
      .MERGE_SETTLE_CYCLES (SETTLE),
      .ITER_WIDTH          (ITER_W)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .meas_valid         (meas_valid),
      .meas_ready         (meas_ready),
      .busy_any           (busy_any),
      .odd_cluster_any    (odd_cluster_any),
      .peel_done_all      (peel_done_all),
      .result_ready       (result_ready),
      .global_stage       (global_stage),
      .result_valid       (result_valid),
      .iteration_count    (iteration_count),
      .iteration_overflow (iteration_overflow),
      .decode_cycles      (decode_cycles)
   );

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic int exp_dc();
`ifdef DECODER_STAGE_CYCLE_COUNT_EN
      return m_dc;
`else
      return 0;
`endif
   endfunction

   // Check the outputs of the current cycle, drive its inputs, advance one clock.
   task automatic step(input logic [2:0] st, input logic mv, input logic bsy,
                       input logic odd, input logic pd, input logic rr);
      check_value("stage", global_stage, st);
      check_value("meas_ready", meas_ready, st == S_IDLE);
      check_value("result_valid", result_valid, st == S_RESULT);
      check_value("iteration_count", iteration_count, m_iter);
      check_value("iteration_overflow", iteration_overflow, m_ovf);
      check_value("decode_cycles", decode_cycles, exp_dc());
      meas_valid      = mv;
      busy_any        = bsy;
      odd_cluster_any = odd;
      peel_done_all   = pd;
      result_ready    = rr;
      @(posedge clk);
      #1;
      if (st inside {S_LOAD, S_GROW, S_MERGE, S_PEEL}) m_dc++;
   endtask

   // One full decode. n_odd: merge decisions that still see an odd cluster.
   // busy_mode: 0 quiet, 1 random busy, 2 single busy pulse on 2nd MERGE cycle.
   task automatic do_decode(input int n_odd, input int busy_mode,
                            input int peel_wait, input int rdy_wait);
      int   idle_run;
      int   mcyc;
      logic bsy;
      logic odd_now;
      step(S_IDLE, 1'b1, rb(), rb(), rb(), rb());
      m_iter = 0;
      m_ovf  = 0;
      m_dc   = 0;
      step(S_LOAD, rb(), rb(), rb(), rb(), rb());
      for (int r = 0; r < 64; r++) begin
         step(S_GROW, rb(), rb(), rb(), rb(), rb());
         m_iter++;
         idle_run = 0;
         mcyc     = 0;
         while (idle_run < SETTLE) begin
            case (busy_mode)
               1:       bsy = (mcyc < 20) && ($urandom_range(0, 3) == 0);
               2:       bsy = (r == 0) && (mcyc == 1);
               default: bsy = 1'b0;
            endcase
            if (!bsy && (idle_run + 1 == SETTLE)) odd_now = (r < n_odd);
            else                                  odd_now = rb();
            step(S_MERGE, rb(), bsy, odd_now, rb(), rb());
            idle_run = bsy ? 0 : idle_run + 1;
            mcyc++;
         end
         if (r >= n_odd) break;
         if (m_iter == MAX_IT) begin
            m_ovf = 1;
            break;
         end
      end
      step(S_PEEL, rb(), rb(), rb(), 1'b1, rb());
      repeat (peel_wait) step(S_PEEL, rb(), rb(), rb(), 1'b0, rb());
      step(S_PEEL, rb(), rb(), rb(), 1'b1, rb());
      repeat (rdy_wait) step(S_RESULT, rb(), rb(), rb(), rb(), 1'b0);
      step(S_RESULT, rb(), rb(), rb(), rb(), 1'b1);
   endtask

   initial begin
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      step(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      step(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      do_decode(0, 0, 0, 10);
      do_decode(2, 0, 0, 1);
      do_decode(9, 0, 1, 0);
      do_decode(0, 2, 0, 0);

      // Reset while peeling must return everything to idle on the next edge.
      step(S_IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      m_iter = 0; m_ovf = 0; m_dc = 0;
      step(S_LOAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(S_GROW, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      m_iter++;
      repeat (SETTLE) step(S_MERGE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step(S_PEEL, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_value("pre_reset_stage", global_stage, S_PEEL);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_iter = 0; m_ovf = 0; m_dc = 0;
      step(S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      for (int t = 0; t < 30; t++) begin
         do_decode($urandom_range(0, 5), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 4));
         repeat ($urandom_range(0, 2)) step(S_IDLE, 1'b0, rb(), rb(), rb(), rb());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/decoder_stage_controller.md
# decoder_stage_controller

Top-level sequencer for the union-find decoding array. Drives the shared `global_stage` bus, which every processing element and `neighbor_link` instance samples. Walks the array through measurement loading, repeated grow/merge rounds until no odd cluster remains, then peeling. Handshakes syndrome input and result output with the host interface.

## Interface
- `MAX_ITERATIONS`, 16: grow rounds allowed before forced peeling; ≥1.
- `MERGE_SETTLE_CYCLES`, 3: consecutive idle cycles of `busy_any` required to end MERGE; ≥1 (covers the OR-tree pipeline depth).
- `ITER_WIDTH`, 8: width of `iteration_count`; must hold `MAX_ITERATIONS`.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `meas_valid` in 1: host has a syndrome round ready.
- `meas_ready` out 1: controller accepts a syndrome round.
- `busy_any` in 1: OR of all PE/link busy flags (root or parent still changing).
- `odd_cluster_any` in 1: OR of all roots reporting an odd, non-boundary cluster; valid when `busy_any` has settled.
- `peel_done_all` in 1: AND of all PE peeling-complete flags.
- `result_ready` in 1: host consumes the result.
- `global_stage` out `STAGE_WIDTH` (3): current stage, registered.
- `result_valid` out 1: `is_error` outputs of the array are final.
- `iteration_count` out `ITER_WIDTH`: grow rounds issued for the current syndrome.
- `iteration_overflow` out 1: peeling was forced at `MAX_ITERATIONS`.
- `decode_cycles` out 32: decode latency (see Configuration).

## Operation
- Stage codes come from the shared parameters include: IDLE=0, MEASUREMENT_LOADING=1, GROW=2, MERGE=3, PEELING=4, RESULT_VALID=5. Codes 6–7 are unreachable and decode to IDLE on the next cycle.
- IDLE: `meas_ready`=1. When `meas_valid`=1, go to MEASUREMENT_LOADING and clear `iteration_count`, `iteration_overflow`, the settle counter and `decode_cycles`.
- MEASUREMENT_LOADING: lasts exactly 1 cycle, during which links clear growth and `is_error`. Then go to GROW.
- GROW: lasts exactly 1 cycle; `iteration_count` increments by 1, saturating. Then go to MERGE.
- MERGE: the settle counter resets to 0 on any cycle with `busy_any`=1, otherwise increments. When the counter reaches `MERGE_SETTLE_CYCLES`, sample `odd_cluster_any`:
  - 0 → PEELING.
  - 1 and `iteration_count` < `MAX_ITERATIONS` → GROW.
  - 1 and `iteration_count` = `MAX_ITERATIONS` → set `iteration_overflow`, go to PEELING.
  - The settle counter clears on MERGE exit.
- PEELING: on a cycle with `peel_done_all`=1, go to RESULT_VALID. `peel_done_all` is ignored on the entry cycle.
- RESULT_VALID: `result_valid`=1. When `result_ready`=1, go to IDLE. `is_error` must stay stable, so the stage holds until `result_ready` is seen.
- `meas_valid` outside IDLE is ignored and not queued; `meas_ready`=0 there.

## Timing
- Reset values: `global_stage`=IDLE, `meas_ready`=1, `result_valid`=0, `iteration_count`=0, `iteration_overflow`=0, `decode_cycles`=0.
- `reset` mid-decode returns to IDLE on the next edge, regardless of state.
- All outputs are registered. `meas_ready` and `result_valid` are decoded from the stage register, with no input-to-output combinational path.
- Accept at edge N → `global_stage`=MEASUREMENT_LOADING at N+1 and GROW at N+2.
- Minimum MERGE dwell is `MERGE_SETTLE_CYCLES` cycles.
- Minimum decode with no defects, from accept to `result_valid`: 1 (load) + 1 (grow) + `MERGE_SETTLE_CYCLES` + 2 (peel) cycles.
- Back-to-back: after the `result_ready` handshake, IDLE lasts at least 1 cycle before the next accept.

## Configuration
- Macro: `DECODER_STAGE_CYCLE_COUNT_EN`.
- Defined:
  - `decode_cycles` is cleared on accept.
  - It increments every cycle the stage is MEASUREMENT_LOADING, GROW, MERGE or PEELING, saturating at 2^32−1.
  - It holds during RESULT_VALID and IDLE.
- Undefined: the port still exists, tied to 0, and no counter is synthesized.

## Test plan
- Reset, then `meas_valid`=1 with `busy_any`=0, `odd_cluster_any`=0, `peel_done_all`=1, `MERGE_SETTLE_CYCLES`=3 → stages 1,2,3,3,3,4,4,5; `iteration_count`=1; `result_valid` held until `result_ready`; `decode_cycles`=7 with macro, 0 without.
- `odd_cluster_any`=1 for the first two MERGE samples, then 0 → stage sequence contains GROW three times; final `iteration_count`=3; `iteration_overflow`=0.
- `MAX_ITERATIONS`=4, `odd_cluster_any` held at 1 → exactly 4 GROW cycles, then PEELING; `iteration_overflow`=1; `iteration_count`=4.
- In MERGE, `busy_any` pulses high on the 2nd idle cycle → settle restarts; MERGE lasts 2+3 cycles before the decision.
- `reset` asserted during PEELING → next cycle `global_stage`=0, `meas_ready`=1, and all counters are 0.
- `meas_valid` toggled during GROW/MERGE → no state change and `meas_ready`=0. `result_ready`=0 for 10 cycles in RESULT_VALID → stage stays 5 and `result_valid`=1 throughout.
